// File: rtl/ertn_ctrl.sv
// ertn_ctrl: exception-return sequencer. Drains memory ops, restores CRMD/LLBCTL/TLBRERA
// and redirects fetch to ERA or TLBRERA.
`default_nettype none

module ertn_ctrl #(
  parameter int DRAIN_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ertn_valid,
  output logic        ertn_ready,
  input  logic        mem_idle,
  input  logic [31:0] csr_crmd,
  input  logic [31:0] csr_prmd,
  input  logic [31:0] csr_era,
  input  logic [31:0] csr_tlbrprmd,
  input  logic [31:0] csr_tlbrera,
  input  logic [31:0] csr_llbctl,
  output logic        crmd_we,
  output logic [31:0] crmd_wdata,
  output logic        tlbrera_we,
  output logic [31:0] tlbrera_wdata,
  output logic        llbctl_we,
  output logic [31:0] llbctl_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic        busy,
  output logic        drain_timeout
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DRAIN    = 2'd1;
  localparam logic [1:0] S_RESTORE  = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(DRAIN_MAX - 1);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [7:0]  drain_cnt;
  logic        is_tlbr;
  logic        timeout_hit;
  logic [31:0] target;
  logic [31:0] crmd_new;
  logic [31:0] llbctl_new;

  wire unused_bits = ^{csr_prmd[31:4], csr_tlbrprmd[31:5], csr_tlbrprmd[3], csr_era[1:0]};

  assign timeout_hit = (state == S_DRAIN) && !mem_idle && (drain_cnt == CNT_LAST);
  assign target      = is_tlbr ? {csr_tlbrera[31:2], 2'b00} : {csr_era[31:2], 2'b00};

  always_comb begin
    crmd_new = csr_crmd;
    if (is_tlbr) begin
      crmd_new[1:0] = csr_tlbrprmd[1:0];
      crmd_new[2]   = csr_tlbrprmd[2];
      crmd_new[9]   = csr_tlbrprmd[4];
      crmd_new[3]   = 1'b0;
      crmd_new[4]   = 1'b1;
    end else begin
      crmd_new[1:0] = csr_prmd[1:0];
      crmd_new[2]   = csr_prmd[2];
      crmd_new[9]   = csr_prmd[3];
    end
  end

  // KLO protects the LL bit across exactly one ERTN: consume KLO, otherwise drop ROLLB.
  always_comb begin
    llbctl_new = csr_llbctl;
    if (csr_llbctl[2]) llbctl_new[2] = 1'b0;
    else               llbctl_new[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt   <= 8'd0;
      is_tlbr     <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          drain_cnt <= 8'd0;
          if (ertn_valid) is_tlbr <= csr_tlbrera[0];
        end
        S_DRAIN: begin
          if (drain_cnt != 8'hFF) drain_cnt <= drain_cnt + 8'd1;
        end
        S_RESTORE: begin
          redirect_pc <= target;
          drain_cnt   <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (ertn_valid) state_nx = S_DRAIN;
      S_DRAIN:    if (mem_idle || timeout_hit) state_nx = S_RESTORE;
      S_RESTORE:  state_nx = S_REDIRECT;
      S_REDIRECT: if (redirect_ack) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ertn_ready     = (state == S_IDLE);
    busy           = (state != S_IDLE);
    redirect_valid = (state == S_REDIRECT);
    drain_timeout  = timeout_hit;
    crmd_we        = 1'b0;
    crmd_wdata     = 32'd0;
    tlbrera_we     = 1'b0;
    tlbrera_wdata  = 32'd0;
    llbctl_we      = 1'b0;
    llbctl_wdata   = 32'd0;
    if (state == S_RESTORE) begin
      crmd_we       = 1'b1;
      crmd_wdata    = crmd_new;
      tlbrera_we    = is_tlbr;
      tlbrera_wdata = {csr_tlbrera[31:1], 1'b0};
      llbctl_we     = 1'b1;
      llbctl_wdata  = llbctl_new;
    end
  end

endmodule

`default_nettype wire
